byte_unstriping: RTL and testbench

//   Receive-side counterpart of the two-lane byte-striping stage: merges the
//   32-bit words arriving on lane 0 and lane 1 back into one ordered stream.

---
 rtl/byte_unstriping_if.sv | 31 +++
 rtl/byte_unstriping.sv | 153 +++++++++++++++
 tb/tb_byte_unstriping.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_unstriping_if.sv
`default_nettype none
// ============================================================================
// Module   : byte_unstriping_if
// Brief    : Lane inputs and merged-stream outputs of the two-lane unstriper.
//            The master drives the lanes; the slave (unstriper) drives the
//            merged word and the sticky overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
interface byte_unstriping_if #(
  parameter int DATA_W = 32
);
  logic              valid_0;
  logic [DATA_W-1:0] lane_0;
  logic              valid_1;
  logic [DATA_W-1:0] lane_1;
  logic              valid_out;
  logic [DATA_W-1:0] Data_out;
  logic              overflow_0;
  logic              overflow_1;

  modport master (
    output valid_0, lane_0, valid_1, lane_1,
    input  valid_out, Data_out, overflow_0, overflow_1
  );

  modport slave (
    input  valid_0, lane_0, valid_1, lane_1,
    output valid_out, Data_out, overflow_0, overflow_1
  );
endinterface
`default_nettype wire

// File: rtl/byte_unstriping.sv
`default_nettype none
// ============================================================================
// Module   : byte_unstriping
// Brief    : Merges words from lane 0 and lane 1 back into one ordered
//            stream (L0, L1, L0, ...). Each lane has its own FIFO to absorb
//            inter-lane skew; a two-state FSM picks which FIFO may pop.
// Revision : 1.0 - initial release
// ============================================================================
module byte_unstriping #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic        clk_2f,
  input  wire logic        reset,
  byte_unstriping_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    WAIT_L0 = 1'b0,
    WAIT_L1 = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]             w_push;
  logic [1:0]             w_pop;
  logic [1:0]             w_empty;
  logic [1:0]             w_full;
  logic [1:0]             w_overflow;
  logic [1:0][DATA_W-1:0] w_lane_data;
  logic [1:0][DATA_W-1:0] w_head;

  logic              r_valid_out;
  logic [DATA_W-1:0] r_data_out;

  assign w_push         = {bus.valid_1, bus.valid_0};
  assign w_lane_data[0] = bus.lane_0;
  assign w_lane_data[1] = bus.lane_1;

  // Per-lane FIFO. Emptiness comes from the registered count, so a word
  // pushed into an empty FIFO becomes poppable one cycle later (no bypass).
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_overflow;
    logic              w_accept;

    assign w_empty[g]    = (r_cnt == '0);
    assign w_full[g]     = (r_cnt == c_cnt_full);
    // A full FIFO still takes the word when its head leaves on the same edge.
    assign w_accept      = w_push[g] & (~w_full[g] | w_pop[g]);
    assign w_head[g]     = r_mem[r_rptr];
    assign w_overflow[g] = r_overflow;

    // Storage array: data only, contents are don't-care while empty.
    always_ff @(posedge clk_2f) begin
      if (w_accept) begin
        r_mem[r_wptr] <= w_lane_data[g];
      end
    end

    // Pointers wrap naturally modulo the power-of-two depth; count tracks fill.
    always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_accept) begin
          r_wptr <= r_wptr + c_ptr_one;
        end
        if (w_pop[g]) begin
          r_rptr <= r_rptr + c_ptr_one;
        end
        case ({w_accept, w_pop[g]})
          2'b10:   r_cnt <= r_cnt + c_cnt_one;
          2'b01:   r_cnt <= r_cnt - c_cnt_one;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    // Sticky flag: a push was dropped because the FIFO was full with no pop.
    always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
        r_overflow <= 1'b0;
      end else if (w_push[g] & w_full[g] & ~w_pop[g]) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_state <= WAIT_L0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pop decision: only the expected lane may pop, so a stall never skips a lane.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 2'b00;
    case (r_state)
      WAIT_L0: begin
        if (!w_empty[0]) begin
          w_pop[0]    = 1'b1;
          w_state_nxt = WAIT_L1;
        end
      end
      WAIT_L1: begin
        if (!w_empty[1]) begin
          w_pop[1]    = 1'b1;
          w_state_nxt = WAIT_L0;
        end
      end
    endcase
  end

  // Output register: load the popped head, otherwise hold the last word.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_valid_out <= |w_pop;
      if (w_pop[0]) begin
        r_data_out <= w_head[0];
      end else if (w_pop[1]) begin
        r_data_out <= w_head[1];
      end
    end
  end

  assign bus.valid_out  = r_valid_out;
  assign bus.Data_out   = r_data_out;
  assign bus.overflow_0 = w_overflow[0];
  assign bus.overflow_1 = w_overflow[1];

endmodule
`default_nettype wire

// File: tb/tb_byte_unstriping.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_unstriping
// Brief    : Directed self-checking bench for byte_unstriping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_unstriping;

  localparam int DATA_W = 32;

  logic clk_2f = 1'b0;
  logic reset  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  byte_unstriping_if #(.DATA_W(DATA_W)) bus ();

  byte_unstriping #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_2f(clk_2f),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2f = ~clk_2f;

  // Drive one cycle of lane inputs, let the rising edge take them, settle.
  task automatic step(input logic v0, input logic [31:0] d0,
                      input logic v1, input logic [31:0] d1);
    bus.valid_0 = v0;
    bus.lane_0  = d0;
    bus.valid_1 = v1;
    bus.lane_1  = d1;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'($urandom_range(1, 0)), $urandom, 1'($urandom_range(1, 0)), $urandom);
      checks++;
      if ({bus.valid_out, bus.overflow_0, bus.overflow_1, bus.Data_out} !== 35'h0) begin
        failures++;
        $display("FAIL reset_outputs: got v=%b ov0=%b ov1=%b d=%h expected all 0",
                 bus.valid_out, bus.overflow_0, bus.overflow_1, bus.Data_out);
      end
    end
    reset = 1'b1;
    // Lane 1 first: must wait for lane 0.
    step(1'b0, 32'h0, 1'b1, 32'h5555_0001);
    idle();
    idle();
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait_l0: got valid_out=%b expected 0", bus.valid_out);
    end
    step(1'b1, 32'h6666_0001, 1'b0, 32'h0);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_bypass: got valid_out=%b expected 0", bus.valid_out);
    end
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'h6666_0001) begin
      failures++;
      $display("FAIL reset_first_l0: got v=%b d=%h expected v=1 d=66660001",
               bus.valid_out, bus.Data_out);
    end
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'h5555_0001) begin
      failures++;
      $display("FAIL reset_then_l1: got v=%b d=%h expected v=1 d=55550001",
               bus.valid_out, bus.Data_out);
    end
    idle();
  endtask

  task automatic test_same_edge();
    step(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222);
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'h1111_1111) begin
      failures++;
      $display("FAIL same_edge_k1: got v=%b d=%h expected v=1 d=11111111",
               bus.valid_out, bus.Data_out);
    end
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'h2222_2222) begin
      failures++;
      $display("FAIL same_edge_k2: got v=%b d=%h expected v=1 d=22222222",
               bus.valid_out, bus.Data_out);
    end
    idle();
    checks++;
    if (bus.valid_out !== 1'b0 || bus.Data_out !== 32'h2222_2222) begin
      failures++;
      $display("FAIL same_edge_k3_hold: got v=%b d=%h expected v=0 d=22222222",
               bus.valid_out, bus.Data_out);
    end
  endtask

  task automatic test_skew();
    step(1'b0, 32'h0, 1'b1, 32'hBBBB_0001);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) step(1'b1, 32'hAAAA_0001, 1'b0, 32'h0);
      else        idle();
      checks++;
      if (bus.valid_out !== 1'b0) begin
        failures++;
        $display("FAIL skew_wait_%0d: got valid_out=%b expected 0", i, bus.valid_out);
      end
    end
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'hAAAA_0001) begin
      failures++;
      $display("FAIL skew_l0: got v=%b d=%h expected v=1 d=aaaa0001",
               bus.valid_out, bus.Data_out);
    end
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'hBBBB_0001) begin
      failures++;
      $display("FAIL skew_l1: got v=%b d=%h expected v=1 d=bbbb0001",
               bus.valid_out, bus.Data_out);
    end
    idle();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_seq [8];
    exp_seq = '{32'hA, 32'h1, 32'hB, 32'h2, 32'hC, 32'h3, 32'hD, 32'h4};
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 32'h0, 1'b1, 32'(i));
      if (i >= 4) begin
        checks++;
        if (bus.overflow_1 !== (i == 5)) begin
          failures++;
          $display("FAIL overflow_1_after_push%0d: got %b expected %b",
                   i, bus.overflow_1, (i == 5));
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 4) step(1'b1, 32'hA + 32'(i), 1'b0, 32'h0);
      else       idle();
      if (i >= 1 && i <= 8) begin
        checks++;
        if (bus.valid_out !== 1'b1 || bus.Data_out !== exp_seq[i-1]) begin
          failures++;
          $display("FAIL overflow_order_%0d: got v=%b d=%h expected v=1 d=%h",
                   i - 1, bus.valid_out, bus.Data_out, exp_seq[i-1]);
        end
      end
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.overflow_1 !== 1'b1 || bus.overflow_0 !== 1'b0) begin
      failures++;
      $display("FAIL overflow_end: got v=%b ov0=%b ov1=%b expected v=0 ov0=0 ov1=1",
               bus.valid_out, bus.overflow_0, bus.overflow_1);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_seq [8];
    exp_seq = '{32'hC001, 32'hF002, 32'hC002, 32'hF003,
                32'hF003 + 32'hD000 - 32'hD000 - 32'h3000 + 32'hC000 - 32'hC000 + 32'h0,
                32'hF004, 32'hC004, 32'hF005};
    // Explicit table: Q1,P2,Q2,P3,Q3,P4,Q4,P5
    exp_seq = '{32'hC001, 32'hF002, 32'hC002, 32'hF003,
                32'hC003, 32'hF004, 32'hC004, 32'hF005};
    step(1'b1, 32'hF000, 1'b0, 32'h0);
    step(1'b1, 32'hF001, 1'b0, 32'h0);
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'hF000) begin
      failures++;
      $display("FAIL fullpop_p0: got v=%b d=%h expected v=1 d=0000f000",
               bus.valid_out, bus.Data_out);
    end
    for (int i = 2; i <= 4; i++) step(1'b1, 32'hF000 + 32'(i), 1'b0, 32'h0);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.overflow_0 !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_fill: got v=%b ov0=%b expected v=0 ov0=0",
               bus.valid_out, bus.overflow_0);
    end
    step(1'b0, 32'h0, 1'b1, 32'hC000);
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'hC000) begin
      failures++;
      $display("FAIL fullpop_q0: got v=%b d=%h expected v=1 d=0000c000",
               bus.valid_out, bus.Data_out);
    end
    // FIFO0 full, state WAIT_L0: push and pop on the same edge.
    step(1'b1, 32'hF005, 1'b0, 32'h0);
    checks++;
    if (bus.overflow_0 !== 1'b0 || bus.valid_out !== 1'b1 || bus.Data_out !== 32'hF001) begin
      failures++;
      $display("FAIL fullpop_accept: got ov0=%b v=%b d=%h expected ov0=0 v=1 d=0000f001",
               bus.overflow_0, bus.valid_out, bus.Data_out);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 4) step(1'b0, 32'h0, 1'b1, 32'hC001 + 32'(i));
      else       idle();
      if (i >= 1 && i <= 8) begin
        checks++;
        if (bus.valid_out !== 1'b1 || bus.Data_out !== exp_seq[i-1]) begin
          failures++;
          $display("FAIL fullpop_drain_%0d: got v=%b d=%h expected v=1 d=%h",
                   i - 1, bus.valid_out, bus.Data_out, exp_seq[i-1]);
        end
      end
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.overflow_0 !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_end: got v=%b ov0=%b expected v=0 ov0=0",
               bus.valid_out, bus.overflow_0);
    end
  endtask

  task automatic test_midstream_reset();
    // Start from a known WAIT_L0 / empty state.
    reset = 1'b0;
    idle();
    reset = 1'b1;
    step(1'b1, 32'h5000_0000, 1'b1, 32'h7000_0000);
    step(1'b1, 32'h5000_0001, 1'b1, 32'h7000_0001);
    step(1'b1, 32'h5000_0002, 1'b0, 32'h0);
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'h5000_0001) begin
      failures++;
      $display("FAIL mid_third_word: got v=%b d=%h expected v=1 d=50000001",
               bus.valid_out, bus.Data_out);
    end
    // Two words (7000_0001, 5000_0002) remain buffered here.
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.valid_out, bus.overflow_0, bus.overflow_1, bus.Data_out} !== 35'h0) begin
      failures++;
      $display("FAIL mid_async_clear: got v=%b ov0=%b ov1=%b d=%h expected all 0",
               bus.valid_out, bus.overflow_0, bus.overflow_1, bus.Data_out);
    end
    @(posedge clk_2f);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(1'b0, 32'h0, 1'b1, 32'h9000_0001);
      else        idle();
      checks++;
      if (bus.valid_out !== 1'b0) begin
        failures++;
        $display("FAIL mid_discard_%0d: got v=%b d=%h expected v=0",
                 i, bus.valid_out, bus.Data_out);
      end
    end
    step(1'b1, 32'h8000_0001, 1'b0, 32'h0);
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'h8000_0001) begin
      failures++;
      $display("FAIL mid_first_l0: got v=%b d=%h expected v=1 d=80000001",
               bus.valid_out, bus.Data_out);
    end
    idle();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.Data_out !== 32'h9000_0001) begin
      failures++;
      $display("FAIL mid_then_l1: got v=%b d=%h expected v=1 d=90000001",
               bus.valid_out, bus.Data_out);
    end
    idle();
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle: got valid_out=%b expected 0", bus.valid_out);
    end
  endtask

  initial begin
    bus.valid_0 = 1'b0;
    bus.lane_0  = '0;
    bus.valid_1 = 1'b0;
    bus.lane_1  = '0;
    test_reset();
    test_same_edge();
    test_skew();
    test_overflow();
    test_full_pop();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
